// File: rtl/lynx_tape_pkg.sv
// Shared types and helpers for the Lynx tape player.
//   state_t      : playback state machine encoding
//   ENTRY_W      : FIFO entry width, {last, data[7:0]}
//   max_int      : larger of two integers (constant-function use)
//   clog2_min1   : $clog2 clamped to at least one bit
package lynx_tape_pkg;

    localparam int ENTRY_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        LOAD,
        WAIT,
        BIT_HI,
        BIT_LO
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lynx_tape_fifo.sv
// Synchronous byte FIFO holding {last, data} entries for the tape player.
// Ports:
//   clock, reset_n : core clock, asynchronous active-low reset
//   flush          : empties the FIFO (takes priority over push/pop)
//   push, din      : write request and entry; ignored while full
//   pop            : read request; ignored while empty
//   dout           : entry at the head (valid while !empty)
//   level          : number of entries held
//   full, empty    : occupancy flags
module lynx_tape_fifo
    import lynx_tape_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       din,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LVW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LVW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // NOTE: storage arrays carry no reset; the level counter guards every
    // read, so stale contents are never observed and the array maps to RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lynx_tape_player.sv
// Cassette-image player: converts queued image bytes into the square-wave
// tape level. Each bit is one high half-period followed by one low
// half-period, HALF0 ce-ticks per half for '0' and HALF1 for '1', MSB first.
// A leader of LEADER_CYCLES '0' bits precedes the first byte.
// Ports:
//   clock, reset_n  : core clock, asynchronous active-low reset
//   ce              : clock enable for all half-period timing
//   play            : rising edge starts, low aborts and flushes the FIFO
//   in_data/in_last/in_valid/in_ready : byte input handshake
//   tape            : registered tape level
//   busy            : player not idle
//   done            : one-clock pulse after the final bit of the last byte
//   underrun        : one-clock pulse when no byte is available at a boundary
//   fifo_level      : bytes currently queued
module lynx_tape_player
    import lynx_tape_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int HALF0         = 1250,
    parameter int HALF1         = 2500,
    parameter int LEADER_CYCLES = 768
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   play,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tape,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int TW = clog2_min1(max_int(HALF0, HALF1));
    localparam int LW = clog2_min1(LEADER_CYCLES + 1);
    localparam logic [TW-1:0] H0_RELOAD   = TW'(HALF0 - 1);
    localparam logic [TW-1:0] H1_RELOAD   = TW'(HALF1 - 1);
    localparam logic [LW-1:0] LEADER_LOAD = LW'(LEADER_CYCLES);
    localparam logic [LW-1:0] LEADER_ONE  = LW'(1);

    state_t               state, state_nx;
    logic                 play_q;
    logic [TW-1:0]        timer, timer_nx;
    logic [LW-1:0]        leader_cnt, leader_cnt_nx;
    logic [7:0]           shreg, shreg_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic                 last_q, last_nx;
    logic                 tape_nx, done_nx, underrun_nx;
    logic                 pop;
    logic                 flush;
    logic                 fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_dout;

    logic play_rise, abort, half_end;

    assign play_rise = play && !play_q;
    assign abort     = (state != IDLE) && !play;
    // The half-period ends on the ce tick that finds the timer already at 0,
    // so a reload of HALF-1 yields exactly HALF ticks.
    assign half_end  = ce && (timer == '0);
    assign flush     = !play && (play_q || state != IDLE);
    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE);

    function automatic logic [TW-1:0] reload_for(input logic bit_val);
        return bit_val ? H1_RELOAD : H0_RELOAD;
    endfunction

    lynx_tape_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (in_valid),
        .din     ({in_last, in_data}),
        .pop     (pop),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   if (play_rise) state_nx = LEADER;
                LEADER: if (half_end && !tape && leader_cnt == LEADER_ONE) state_nx = LOAD;
                LOAD:   state_nx = fifo_empty ? WAIT : BIT_HI;
                WAIT:   if (!fifo_empty) state_nx = LOAD;
                BIT_HI: if (half_end) state_nx = BIT_LO;
                BIT_LO: begin
                    if (half_end) begin
                        if (bit_idx != 3'd0) state_nx = BIT_HI;
                        else if (last_q)     state_nx = IDLE;
                        else                 state_nx = LOAD;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output and datapath logic.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        timer_nx      = timer;
        leader_cnt_nx = leader_cnt;
        shreg_nx      = shreg;
        bit_idx_nx    = bit_idx;
        last_nx       = last_q;
        tape_nx       = tape;
        done_nx       = 1'b0;
        underrun_nx   = 1'b0;
        pop           = 1'b0;

        if ((state == LEADER || state == BIT_HI || state == BIT_LO) && ce && timer != '0) begin
            timer_nx = timer - 1'b1;
        end

        if (abort) begin
            tape_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tape_nx = 1'b0;
                    if (play_rise) begin
                        tape_nx       = 1'b1;
                        timer_nx      = H0_RELOAD;
                        leader_cnt_nx = LEADER_LOAD;
                    end
                end
                LEADER: begin
                    if (half_end) begin
                        if (tape) begin
                            tape_nx  = 1'b0;
                            timer_nx = H0_RELOAD;
                        end else if (leader_cnt != LEADER_ONE) begin
                            leader_cnt_nx = leader_cnt - 1'b1;
                            tape_nx       = 1'b1;
                            timer_nx      = H0_RELOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_nx   = fifo_dout[7:0];
                        last_nx    = fifo_dout[8];
                        bit_idx_nx = 3'd7;
                        timer_nx   = reload_for(fifo_dout[7]);
                        tape_nx    = 1'b1;
                    end else begin
                        underrun_nx = 1'b1;
                        tape_nx     = 1'b0;
                    end
                end
                WAIT: begin
                    tape_nx = 1'b0;
                end
                BIT_HI: begin
                    if (half_end) begin
                        tape_nx  = 1'b0;
                        timer_nx = reload_for(shreg[7]);
                    end
                end
                BIT_LO: begin
                    if (half_end) begin
                        if (bit_idx != 3'd0) begin
                            bit_idx_nx = bit_idx - 1'b1;
                            shreg_nx   = shreg << 1;
                            timer_nx   = reload_for(shreg[6]);
                            tape_nx    = 1'b1;
                        end else if (last_q) begin
                            done_nx = 1'b1;
                        end
                    end
                end
                default: tape_nx = 1'b0;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // play_q starts high so a play line already high out of reset
            // does not look like a rising edge.
            play_q     <= 1'b1;
            timer      <= '0;
            leader_cnt <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            last_q     <= 1'b0;
            tape       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            play_q     <= play;
            timer      <= timer_nx;
            leader_cnt <= leader_cnt_nx;
            shreg      <= shreg_nx;
            bit_idx    <= bit_idx_nx;
            last_q     <= last_nx;
            tape       <= tape_nx;
            done       <= done_nx;
            underrun   <= underrun_nx;
        end
    end

endmodule
